// File: rtl/w5300_pkg.sv
// Shared W5300 bring-up constants: register map, sequencer state encoding,
// error codes and the init-table entry layout.
package w5300_pkg;

    localparam logic [9:0] ADDR_MR   = 10'h000;
    localparam logic [9:0] ADDR_IR   = 10'h002;
    localparam logic [9:0] ADDR_IMR  = 10'h004;
    localparam logic [9:0] ADDR_SHAR = 10'h008;
    localparam logic [9:0] ADDR_GAR  = 10'h010;
    localparam logic [9:0] ADDR_SUBR = 10'h014;
    localparam logic [9:0] ADDR_SIPR = 10'h018;

    // Writes occupy steps 0..10, verify reads steps 11..19.
    localparam int N_WRITES = 11;
    localparam int N_READS  = 9;
    localparam int N_STEPS  = N_WRITES + N_READS;
    localparam int STEP_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_WRITE,
        ST_GAP,
        ST_VERIFY,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_VERIFY  = 2'd2
    } err_code_t;

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [15:0] data;
        logic [15:0] expected;
    } rom_entry_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/w5300_init_rom.sv
// Combinational init table: step index -> bus access (write pass, then verify reads).
module w5300_init_rom
    import w5300_pkg::*;
#(
    parameter logic [15:0] MR_VALUE  = 16'hB800,
    parameter logic [47:0] MAC_ADDR  = 48'h0008DC010203,
    parameter logic [31:0] GW_ADDR   = 32'hC0A80101,
    parameter logic [31:0] SUB_MASK  = 32'hFFFFFF00,
    parameter logic [31:0] IP_ADDR   = 32'hC0A8010A,
    parameter logic [15:0] IMR_VALUE = 16'h0000
) (
    input  logic [STEP_W-1:0] idx,
    output rom_entry_t        entry
);

    function automatic rom_entry_t wr_e(input logic [9:0] a, input logic [15:0] d);
        return {1'b1, a, d, d};
    endfunction

    function automatic rom_entry_t rd_e(input logic [9:0] a, input logic [15:0] d);
        return {1'b0, a, 16'h0000, d};
    endfunction

    always_comb begin
        entry = '0;
        case (idx)
            5'd0:  entry = wr_e(ADDR_MR,           MR_VALUE);
            5'd1:  entry = wr_e(ADDR_SHAR,         MAC_ADDR[47:32]);
            5'd2:  entry = wr_e(ADDR_SHAR + 10'd2, MAC_ADDR[31:16]);
            5'd3:  entry = wr_e(ADDR_SHAR + 10'd4, MAC_ADDR[15:0]);
            5'd4:  entry = wr_e(ADDR_GAR,          GW_ADDR[31:16]);
            5'd5:  entry = wr_e(ADDR_GAR + 10'd2,  GW_ADDR[15:0]);
            5'd6:  entry = wr_e(ADDR_SUBR,         SUB_MASK[31:16]);
            5'd7:  entry = wr_e(ADDR_SUBR + 10'd2, SUB_MASK[15:0]);
            5'd8:  entry = wr_e(ADDR_SIPR,         IP_ADDR[31:16]);
            5'd9:  entry = wr_e(ADDR_SIPR + 10'd2, IP_ADDR[15:0]);
            5'd10: entry = wr_e(ADDR_IMR,          IMR_VALUE);
            // Verify reads cover the network registers in write order.
            5'd11: entry = rd_e(ADDR_SHAR,         MAC_ADDR[47:32]);
            5'd12: entry = rd_e(ADDR_SHAR + 10'd2, MAC_ADDR[31:16]);
            5'd13: entry = rd_e(ADDR_SHAR + 10'd4, MAC_ADDR[15:0]);
            5'd14: entry = rd_e(ADDR_GAR,          GW_ADDR[31:16]);
            5'd15: entry = rd_e(ADDR_GAR + 10'd2,  GW_ADDR[15:0]);
            5'd16: entry = rd_e(ADDR_SUBR,         SUB_MASK[31:16]);
            5'd17: entry = rd_e(ADDR_SUBR + 10'd2, SUB_MASK[15:0]);
            5'd18: entry = rd_e(ADDR_SIPR,         IP_ADDR[31:16]);
            5'd19: entry = rd_e(ADDR_SIPR + 10'd2, IP_ADDR[15:0]);
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/w5300_init_ctrl.sv
// W5300 bring-up sequencer: chip reset, PLL wait, register writes, read-back
// verify with retries, and ready/err reporting toward top-level control.
module w5300_init_ctrl
    import w5300_pkg::*;
#(
    parameter int          RST_LOW_CYC  = 500,
    parameter int          RST_WAIT_CYC = 1_000_000,
    parameter int          ACK_TIMEOUT  = 255,
    parameter int          MAX_RETRY    = 3,
    parameter logic [15:0] MR_VALUE     = 16'hB800,
    parameter logic [47:0] MAC_ADDR     = 48'h0008DC010203,
    parameter logic [31:0] GW_ADDR      = 32'hC0A80101,
    parameter logic [31:0] SUB_MASK     = 32'hFFFFFF00,
    parameter logic [31:0] IP_ADDR      = 32'hC0A8010A,
    parameter logic [15:0] IMR_VALUE    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        wrst_n,
    output logic        req,
    output logic        req_wr,
    output logic [9:0]  req_addr,
    output logic [15:0] req_wdata,
    input  logic        ack,
    input  logic [15:0] rdata,
    output logic        busy,
    output logic        ready,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int T_MAX = max3(RST_LOW_CYC, RST_WAIT_CYC, ACK_TIMEOUT);
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int RW    = $clog2(MAX_RETRY + 1);

    state_t              state, state_nx;
    logic [TW-1:0]       timer;
    logic [STEP_W-1:0]   idx, idx_nx;
    logic [RW-1:0]       retry, retry_nx;
    err_code_t           code, code_nx;
    logic                boot_pend;
    rom_entry_t          entry;

    w5300_init_rom #(
        .MR_VALUE  (MR_VALUE),
        .MAC_ADDR  (MAC_ADDR),
        .GW_ADDR   (GW_ADDR),
        .SUB_MASK  (SUB_MASK),
        .IP_ADDR   (IP_ADDR),
        .IMR_VALUE (IMR_VALUE)
    ) u_rom (
        .idx   (idx),
        .entry (entry)
    );

    // boot_pend lets the first cycle out of reset launch the chip reset without start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            idx       <= '0;
            retry     <= '0;
            code      <= ERR_NONE;
            boot_pend <= 1'b1;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            retry     <= retry_nx;
            code      <= code_nx;
            boot_pend <= 1'b0;
            if (state_nx != state)
                timer <= '0;
            else if (timer != TW'(T_MAX))
                timer <= timer + TW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        retry_nx = retry;
        code_nx  = code;
        wrst_n   = 1'b1;
        req      = 1'b0;
        busy     = 1'b0;
        ready    = 1'b0;
        err      = 1'b0;
        case (state)
            ST_IDLE: begin
                wrst_n = 1'b0;
                if (start || boot_pend)
                    state_nx = ST_RST_LOW;
            end
            ST_RST_LOW: begin
                wrst_n = 1'b0;
                busy   = 1'b1;
                if (timer == TW'(RST_LOW_CYC - 1))
                    state_nx = ST_RST_WAIT;
            end
            ST_RST_WAIT: begin
                busy = 1'b1;
                if (timer == TW'(RST_WAIT_CYC - 1)) begin
                    state_nx = ST_WRITE;
                    idx_nx   = '0;
                    retry_nx = '0;
                end
            end
            ST_WRITE, ST_VERIFY: begin
                busy = 1'b1;
                req  = 1'b1;
                // An ack in the final allowed cycle still counts as completion.
                if (ack) begin
                    if (state == ST_VERIFY && rdata != entry.expected) begin
                        if (retry < RW'(MAX_RETRY - 1)) begin
                            retry_nx = retry + RW'(1);
                            idx_nx   = '0;
                            state_nx = ST_GAP;
                        end else begin
                            code_nx  = ERR_VERIFY;
                            state_nx = ST_ERROR;
                        end
                    end else if (idx == STEP_W'(N_STEPS - 1)) begin
                        state_nx = ST_DONE;
                    end else begin
                        idx_nx   = idx + STEP_W'(1);
                        state_nx = ST_GAP;
                    end
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    code_nx  = ERR_TIMEOUT;
                    state_nx = ST_ERROR;
                end
            end
            ST_GAP: begin
                busy     = 1'b1;
                state_nx = entry.wr ? ST_WRITE : ST_VERIFY;
            end
            ST_DONE: begin
                ready = 1'b1;
                if (start)
                    state_nx = ST_RST_LOW;
            end
            ST_ERROR: begin
                err = 1'b1;
                if (start) begin
                    code_nx  = ERR_NONE;
                    state_nx = ST_RST_LOW;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign req_wr    = req & entry.wr;
    assign req_addr  = req ? entry.addr : 10'd0;
    assign req_wdata = (req && entry.wr) ? entry.data : 16'h0000;
    assign err_code  = err ? code : ERR_NONE;

endmodule

// File: tb/tb_w5300_init_ctrl.sv
// Bench for w5300_init_ctrl: a bus model on the req/ack port plus directed
// bring-up, retry, error, reset and start-handling sequences.
module tb_w5300_init_ctrl;

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic        clk;
    logic        rst_n, start;
    logic        wrst_n, req, req_wr, ack, busy, ready, err;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata, rdata;
    logic [1:0]  err_code;

    int passed = 0;
    int total  = 0;

    logic        ack_m, spur;
    assign ack = ack_m | spur;

    w5300_init_ctrl #(
        .RST_LOW_CYC  (4),
        .RST_WAIT_CYC (16),
        .ACK_TIMEOUT  (8),
        .MAX_RETRY    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wrst_n    (wrst_n),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .ready     (ready),
        .err       (err),
        .err_code  (err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus model ----------------
    logic [15:0] mem [0:511];
    txn_t        log_q[$];
    int          wait_cnt, req_len, last_len, wr_acks, bad_gap, bad_stable, corrupt_left;
    int          low_run;
    bit          read_zero, nack5;
    logic        req_q, h_wr;
    logic [9:0]  h_addr;
    logic [15:0] h_wdata;

    initial begin
        ack_m = 1'b0; rdata = 16'h0; req_q = 1'b0;
        wait_cnt = 0; req_len = 0; last_len = 0; wr_acks = 0;
        bad_gap = 0; bad_stable = 0; low_run = 1000;
        h_wr = 1'b0; h_addr = '0; h_wdata = '0;
        forever begin
            @(negedge clk);
            ack_m = 1'b0;
            if (req) begin
                if (!req_q) begin
                    if (low_run < 20 && low_run != 1) bad_gap++;
                    h_addr = req_addr; h_wr = req_wr; h_wdata = req_wdata;
                    wait_cnt = 0; req_len = 0;
                end else if (req_addr != h_addr || req_wr != h_wr || (req_wr && req_wdata != h_wdata)) begin
                    bad_stable++;
                end
                wait_cnt++; req_len++; low_run = 0;
                if (wait_cnt == 2 && !(nack5 && req_wr && wr_acks == 4)) begin
                    ack_m = 1'b1;
                    if (req_wr) begin
                        mem[req_addr[9:1]] = req_wdata;
                        wr_acks++;
                    end else if (read_zero) begin
                        rdata = 16'h0000;
                    end else if (corrupt_left > 0 && req_addr == 10'h01A) begin
                        rdata = ~mem[req_addr[9:1]];
                        corrupt_left--;
                    end else begin
                        rdata = mem[req_addr[9:1]];
                    end
                    log_q.push_back({req_wr, req_addr, req_wr ? req_wdata : 16'h0000});
                end
            end else begin
                if (req_q) last_len = req_len;
                low_run++;
            end
            req_q = req;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return ready | err;
            1: return req & req_wr;
            2: return req & ~req_wr;
            default: return wrst_n;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int max_cyc, input string name);
        int n = 0;
        while (!cond(sel) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!cond(sel)) check({name, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic measure_reset(output int low_n, output int wait_n);
        low_n = 0; wait_n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req) break;
            if (!wrst_n && busy) low_n++;
            else if (wrst_n && busy) wait_n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " wrst_n"},   wrst_n,   0);
        check({tag, " req"},      req,      0);
        check({tag, " req_wr"},   req_wr,   0);
        check({tag, " req_addr"}, req_addr, 0);
        check({tag, " wdata"},    req_wdata, 0);
        check({tag, " busy"},     busy,     0);
        check({tag, " ready"},    ready,    0);
        check({tag, " err"},      err,      0);
        check({tag, " err_code"}, err_code, 0);
    endtask

    // ---------------- test ----------------
    txn_t exp_tbl [0:19];
    int   low_n, wait_n, lows;

    initial begin
        exp_tbl[0]  = {1'b1, 10'h000, 16'hB800};
        exp_tbl[1]  = {1'b1, 10'h008, 16'h0008};
        exp_tbl[2]  = {1'b1, 10'h00A, 16'hDC01};
        exp_tbl[3]  = {1'b1, 10'h00C, 16'h0203};
        exp_tbl[4]  = {1'b1, 10'h010, 16'hC0A8};
        exp_tbl[5]  = {1'b1, 10'h012, 16'h0101};
        exp_tbl[6]  = {1'b1, 10'h014, 16'hFFFF};
        exp_tbl[7]  = {1'b1, 10'h016, 16'hFF00};
        exp_tbl[8]  = {1'b1, 10'h018, 16'hC0A8};
        exp_tbl[9]  = {1'b1, 10'h01A, 16'h010A};
        exp_tbl[10] = {1'b1, 10'h004, 16'h0000};
        exp_tbl[11] = {1'b0, 10'h008, 16'h0000};
        exp_tbl[12] = {1'b0, 10'h00A, 16'h0000};
        exp_tbl[13] = {1'b0, 10'h00C, 16'h0000};
        exp_tbl[14] = {1'b0, 10'h010, 16'h0000};
        exp_tbl[15] = {1'b0, 10'h012, 16'h0000};
        exp_tbl[16] = {1'b0, 10'h014, 16'h0000};
        exp_tbl[17] = {1'b0, 10'h016, 16'h0000};
        exp_tbl[18] = {1'b0, 10'h018, 16'h0000};
        exp_tbl[19] = {1'b0, 10'h01A, 16'h0000};

        rst_n = 1'b0; start = 1'b0; spur = 1'b0;
        read_zero = 0; nack5 = 0; corrupt_left = 0;
        repeat (3) @(negedge clk);

        // 1: power-up bring-up
        check_reset_vals("s1 reset");
        rst_n = 1'b1;
        measure_reset(low_n, wait_n);
        check("s1 wrst_n low cycles", low_n, 4);
        check("s1 wait cycles", wait_n, 16);
        wait_for(0, 300, "s1 done");
        check("s1 ready", ready, 1);
        check("s1 busy", busy, 0);
        check("s1 err", err, 0);
        check("s1 wrst_n high", wrst_n, 1);
        check("s1 txn count", log_q.size(), 20);
        for (int i = 0; i < 20; i++)
            check($sformatf("s1 txn%0d", i), (i < log_q.size()) ? log_q[i] : '1, exp_tbl[i]);
        check("s1 gaps", bad_gap, 0);
        check("s1 stable", bad_stable, 0);

        // 2: one corrupted SIPR read forces a second pass
        log_q.delete();
        corrupt_left = 1;
        pulse_start();
        wait_for(0, 500, "s2 done");
        check("s2 ready", ready, 1);
        check("s2 err", err, 0);
        check("s2 txn count", log_q.size(), 40);
        check("s2 pass2 first", (log_q.size() > 20) ? log_q[20] : '1, exp_tbl[0]);
        check("s2 pass2 last", (log_q.size() > 39) ? log_q[39] : '1, exp_tbl[19]);
        check("s2 gaps", bad_gap, 0);

        // 3: reads always zero -> verify error after three passes
        log_q.delete();
        read_zero = 1;
        pulse_start();
        wait_for(0, 500, "s3 done");
        check("s3 err", err, 1);
        check("s3 err_code", err_code, 2);
        check("s3 ready", ready, 0);
        check("s3 busy", busy, 0);
        check("s3 wrst_n", wrst_n, 1);
        check("s3 txn count", log_q.size(), 36);
        check("s3 last txn", (log_q.size() > 35) ? log_q[35] : '1, exp_tbl[11]);

        // 4: 5th write never acked -> timeout
        read_zero = 0; nack5 = 1; wr_acks = 0;
        pulse_start();
        check("s4 err cleared", err, 0);
        check("s4 err_code cleared", err_code, 0);
        check("s4 busy", busy, 1);
        check("s4 wrst_n low", wrst_n, 0);
        wait_for(0, 300, "s4 done");
        @(negedge clk);
        check("s4 err", err, 1);
        check("s4 err_code", err_code, 1);
        check("s4 req", req, 0);
        check("s4 req length", last_len, 8);
        check("s4 writes acked", wr_acks, 4);

        // 5: reset pulse mid-VERIFY
        nack5 = 0;
        pulse_start();
        wait_for(2, 300, "s5 verify");
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("s5 reset");
        rst_n = 1'b1;
        measure_reset(low_n, wait_n);
        check("s5 wrst_n low cycles", low_n, 4);
        check("s5 wait cycles", wait_n, 16);
        wait_for(0, 300, "s5 done");
        check("s5 ready", ready, 1);

        // 6: start in DONE restarts; spurious ack and start-while-busy ignored
        log_q.delete();
        pulse_start();
        check("s6 ready cleared", ready, 0);
        check("s6 wrst_n low", wrst_n, 0);
        check("s6 busy", busy, 1);
        wait_for(3, 50, "s6 rst_wait");
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("s6 req after spur ack", req, 0);
        check("s6 busy after spur ack", busy, 1);
        wait_for(1, 50, "s6 write");
        pulse_start();
        lows = 0;
        for (int i = 0; i < 300 && !ready; i++) begin
            if (!wrst_n) lows++;
            @(negedge clk);
        end
        check("s6 no restart", lows, 0);
        check("s6 ready", ready, 1);
        check("s6 txn count", log_q.size(), 20);
        check("s6 first txn", (log_q.size() > 0) ? log_q[0] : '1, exp_tbl[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
